arb_rr_bin: RTL and testbench



---
 rtl/arb_rr_bin.sv | 260 ++++++++++++++++++++++++++
 tb/tb_arb_rr_bin.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/arb_rr_bin.sv
// arb_rr_bin: round-robin arbiter with a registered binary grant index.
//
// Picks one of WIDTH requesters and presents its index on `bin`, ready to
// drive the select input of a downstream mux_bin. The grant is registered and
// held until the consumer accepts it (vld & rdy), so the selected mux data is
// stable for the whole handshake. After each transfer the pointer moves to the
// slot after the served requester, and the next grant is computed in the same
// cycle, so back-to-back transfers have no bubble.
//
// Parameters:
//   WIDTH      number of requesters (>= 2, any value)
//   SPLIT      radix of the priority-encoder tree
//   WIDTH_LOG  grant index width, $clog2(WIDTH)
//
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   synchronous active-low reset
//   req    in   request vector, bit i = requester i
//   lst    in   last beat of the current transfer (packet mode only)
//   vld    out  grant valid
//   rdy    in   downstream accepts grant
//   bin    out  binary grant index
//   oh     out  one-hot grant, 1 << bin when vld, else 0
//
// Optional feature macro: ARB_RR_BIN_PACKET_EN
//   Defined:   a transfer with lst=0 locks the grant (no re-arbitration) until
//              a transfer with lst=1.
//   Undefined: lst is ignored and every transfer re-arbitrates.

module arb_rr_bin #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SPLIT = 4,
    localparam int unsigned WIDTH_LOG = $clog2(WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     req,
    input  logic                 lst,
    output logic                 vld,
    input  logic                 rdy,
    output logic [WIDTH_LOG-1:0] bin,
    output logic [WIDTH-1:0]     oh
);

    // ------------------------------------------------------------------
    // Tree geometry
    // ------------------------------------------------------------------
    function automatic int unsigned tree_levels(int unsigned n, int unsigned s);
        int unsigned lvl;
        int unsigned cap;
        lvl = 0;
        cap = 1;
        while (cap < n) begin
            cap = cap * s;
            lvl = lvl + 1;
        end
        return lvl;
    endfunction

    function automatic int unsigned tree_pow(int unsigned s, int unsigned e);
        int unsigned p;
        p = 1;
        for (int unsigned i = 0; i < e; i++) begin
            p = p * s;
        end
        return p;
    endfunction

    localparam int unsigned LEVELS = tree_levels(WIDTH, SPLIT);
    localparam int unsigned NPAD   = tree_pow(SPLIT, LEVELS);
    localparam int unsigned IW     = $clog2(NPAD);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
`ifdef ARB_RR_BIN_PACKET_EN
    typedef enum logic [1:0] {StIdle, StGrant, StLock} state_e;
`else
    typedef enum logic [1:0] {StIdle, StGrant} state_e;
`endif

    state_e                 state_q, state_d;
    logic                   vld_q, vld_d;
    logic [WIDTH_LOG-1:0]   bin_q, bin_d;
    logic [WIDTH-1:0]       oh_q, oh_d;
    logic [WIDTH_LOG-1:0]   ptr_q, ptr_d;

    logic                   xfer;
    logic [WIDTH_LOG-1:0]   nxt_ptr;
    logic [WIDTH_LOG-1:0]   arb_ptr;
    logic [WIDTH-1:0]       req_hi;
    logic                   arb_found;
    logic [WIDTH_LOG-1:0]   arb_bin;
    logic [WIDTH-1:0]       arb_oh;

    assign xfer    = vld_q & rdy;
    assign nxt_ptr = (bin_q == WIDTH_LOG'(WIDTH - 1)) ? '0 : bin_q + WIDTH_LOG'(1);
    // On a transfer the search already starts from the post-transfer pointer,
    // which is what gives zero-bubble back-to-back grants.
    assign arb_ptr = xfer ? nxt_ptr : ptr_q;

    // ------------------------------------------------------------------
    // Cyclic priority search
    //
    // Two lowest-index-first trees run in parallel: tree 0 sees only requests
    // at or above the pointer, tree 1 sees all requests. A hit in tree 0 is
    // the first requester in cyclic order; otherwise the search wrapped and
    // tree 1 gives the answer.
    // ------------------------------------------------------------------
    always_comb begin
        req_hi = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            req_hi[i] = req[i] & (WIDTH_LOG'(i) >= arb_ptr);
        end
    end

    logic [NPAD-1:0] leaf_pad [2];
    logic            node_vld [2][LEVELS+1][NPAD];
    logic [IW-1:0]   node_idx [2][LEVELS+1][NPAD];

    assign leaf_pad[0] = NPAD'(req_hi);
    assign leaf_pad[1] = NPAD'(req);

    always_comb begin
        for (int t = 0; t < 2; t++) begin
            for (int l = 0; l <= int'(LEVELS); l++) begin
                for (int n = 0; n < int'(NPAD); n++) begin
                    node_vld[t][l][n] = 1'b0;
                    node_idx[t][l][n] = '0;
                end
            end
            for (int n = 0; n < int'(NPAD); n++) begin
                node_vld[t][0][n] = leaf_pad[t][n];
                node_idx[t][0][n] = IW'(n);
            end
            // Each node scans its SPLIT children high to low so the lowest
            // valid child wins.
            for (int l = 0; l < int'(LEVELS); l++) begin
                for (int n = 0; n < int'(NPAD / SPLIT); n++) begin
                    for (int c = int'(SPLIT) - 1; c >= 0; c--) begin
                        if (node_vld[t][l][n*int'(SPLIT)+c]) begin
                            node_vld[t][l+1][n] = 1'b1;
                            node_idx[t][l+1][n] = node_idx[t][l][n*int'(SPLIT)+c];
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        arb_found = node_vld[0][LEVELS][0] | node_vld[1][LEVELS][0];
        if (node_vld[0][LEVELS][0]) begin
            arb_bin = WIDTH_LOG'(node_idx[0][LEVELS][0]);
        end else begin
            arb_bin = WIDTH_LOG'(node_idx[1][LEVELS][0]);
        end
        arb_oh = WIDTH'(1) << arb_bin;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        vld_d   = vld_q;
        bin_d   = bin_q;
        oh_d    = oh_q;
        ptr_d   = ptr_q;

        case (state_q)
            StIdle: begin
                // rdy is meaningless while vld=0
                if (arb_found) begin
                    state_d = StGrant;
                    vld_d   = 1'b1;
                    bin_d   = arb_bin;
                    oh_d    = arb_oh;
                end
            end

            StGrant: begin
                if (xfer) begin
`ifdef ARB_RR_BIN_PACKET_EN
                    if (!lst) begin
                        // Mid-packet: keep bin, oh and ptr exactly as they are.
                        state_d = StLock;
                    end else
`endif
                    begin
                        ptr_d = nxt_ptr;
                        if (arb_found) begin
                            vld_d = 1'b1;
                            bin_d = arb_bin;
                            oh_d  = arb_oh;
                        end else begin
                            state_d = StIdle;
                            vld_d   = 1'b0;
                            oh_d    = '0;
                        end
                    end
                end
            end

`ifdef ARB_RR_BIN_PACKET_EN
            StLock: begin
                // Grant stays valid regardless of req until the last beat.
                if (xfer && lst) begin
                    ptr_d = nxt_ptr;
                    if (arb_found) begin
                        state_d = StGrant;
                        vld_d   = 1'b1;
                        bin_d   = arb_bin;
                        oh_d    = arb_oh;
                    end else begin
                        state_d = StIdle;
                        vld_d   = 1'b0;
                        oh_d    = '0;
                    end
                end
            end
`endif

            default: begin
                state_d = StIdle;
                vld_d   = 1'b0;
                oh_d    = '0;
            end
        endcase
    end

`ifndef ARB_RR_BIN_PACKET_EN
    logic unused_lst;
    assign unused_lst = lst;
`endif

    // ------------------------------------------------------------------
    // Registers (synchronous active-low reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            vld_q   <= 1'b0;
            bin_q   <= '0;
            oh_q    <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            vld_q   <= vld_d;
            bin_q   <= bin_d;
            oh_q    <= oh_d;
            ptr_q   <= ptr_d;
        end
    end

    assign vld = vld_q;
    assign bin = bin_q;
    assign oh  = oh_q;

endmodule

// File: tb/tb_arb_rr_bin.sv
// Directed, table-driven bench for arb_rr_bin (WIDTH=16) plus a short
// hand-written wrap-around sequence on a WIDTH=10 instance.

module tb_arb_rr_bin;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] req;
    logic        lst;
    logic        rdy;
    logic        vld;
    logic [3:0]  bin;
    logic [15:0] oh;

    logic [9:0]  req10;
    logic        rdy10;
    logic        lst10;
    logic        vld10;
    logic [3:0]  bin10;
    logic [9:0]  oh10;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    arb_rr_bin #(
        .WIDTH (16),
        .SPLIT (4)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .lst   (lst),
        .vld   (vld),
        .rdy   (rdy),
        .bin   (bin),
        .oh    (oh)
    );

    arb_rr_bin #(
        .WIDTH (10),
        .SPLIT (4)
    ) u_dut10 (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req10),
        .lst   (lst10),
        .vld   (vld10),
        .rdy   (rdy10),
        .bin   (bin10),
        .oh    (oh10)
    );

    typedef struct {
        logic        rst_n;
        logic [15:0] req;
        logic        rdy;
        logic        lst;
        logic        exp_vld;
        logic [3:0]  exp_bin;
        logic        chk_bin;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic [15:0] q, input logic y,
                                input logic l, input logic ev, input logic [3:0] eb,
                                input logic cb);
        vec_t v;
        v.rst_n   = r;
        v.req     = q;
        v.rdy     = y;
        v.lst     = l;
        v.exp_vld = ev;
        v.exp_bin = eb;
        v.chk_bin = cb;
        vecs.push_back(v);
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp_oh;
        logic [9:0]  exp_oh10;
        logic [3:0]  exp10;

        rst_n = 1'b0;
        req   = '0;
        rdy   = 1'b0;
        lst   = 1'b1;
        req10 = '0;
        rdy10 = 1'b0;
        lst10 = 1'b1;

        // args: rst_n, req, rdy, lst, exp_vld, exp_bin, chk_bin
        // Reset, then idle
        add(0, 16'h0000, 0, 1, 0, 0, 1);
        for (int i = 0; i < 5; i++) add(1, 16'h0000, 0, 1, 0, 0, 1);
        // Single requester, grant held under back-pressure after req drops
        add(1, 16'h0001, 0, 1, 1, 0, 1);
        for (int i = 0; i < 4; i++) add(1, 16'h0000, 0, 1, 1, 0, 1);
        add(1, 16'h0000, 1, 1, 0, 0, 0);
        add(1, 16'h0000, 1, 1, 0, 0, 0);  // rdy while idle is ignored
        // All requesting: 0..15 then 0, no bubble
        add(0, 16'h0000, 0, 1, 0, 0, 1);
        for (int i = 0; i < 17; i++) add(1, 16'hFFFF, 1, 1, 1, 4'(i % 16), 1);
        // Wrap-around between the two end requesters
        add(0, 16'h0000, 0, 1, 0, 0, 1);
        for (int i = 0; i < 5; i++) add(1, 16'h8001, 1, 1, 1, (i % 2 == 1) ? 4'd15 : 4'd0, 1);
        // Fairness: 0,1,4 repeat while all keep requesting
        add(0, 16'h0000, 0, 1, 0, 0, 1);
        add(1, 16'h0013, 1, 1, 1, 0, 1);
        add(1, 16'h0013, 1, 1, 1, 1, 1);
        add(1, 16'h0013, 1, 1, 1, 4, 1);
        add(1, 16'h0013, 1, 1, 1, 0, 1);
        add(1, 16'h0013, 1, 1, 1, 1, 1);
        // Reset while vld=1, bin=5, rdy=1: grant dropped, ptr back to 0
        add(0, 16'h0000, 0, 1, 0, 0, 1);
        add(1, 16'h0021, 1, 1, 1, 0, 1);
        add(1, 16'h0021, 1, 1, 1, 5, 1);
        add(0, 16'h0021, 1, 1, 0, 0, 1);
        add(1, 16'h0021, 0, 1, 1, 0, 1);
        add(1, 16'h0000, 1, 1, 0, 0, 0);
        add(1, 16'h0020, 0, 1, 1, 5, 1);
        add(1, 16'h0000, 1, 1, 0, 0, 0);
        // Packet mode: lst=0,0,1 on the three beats of the first grant
        add(0, 16'h0000, 0, 1, 0, 0, 1);
        add(1, 16'h0006, 1, 0, 1, 1, 1);
`ifdef ARB_RR_BIN_PACKET_EN
        add(1, 16'h0006, 1, 0, 1, 1, 1);
        add(1, 16'h0006, 1, 0, 1, 1, 1);
        add(1, 16'h0006, 1, 1, 1, 2, 1);
        add(1, 16'h0000, 1, 0, 1, 2, 1);  // locked: vld holds without req
        add(1, 16'h0000, 1, 1, 0, 0, 0);
`else
        add(1, 16'h0006, 1, 0, 1, 2, 1);
        add(1, 16'h0006, 1, 0, 1, 1, 1);
        add(1, 16'h0006, 1, 1, 1, 2, 1);
        add(1, 16'h0000, 1, 0, 0, 0, 0);
        add(1, 16'h0000, 1, 1, 0, 0, 0);
`endif

        foreach (vecs[i]) begin
            rst_n = vecs[i].rst_n;
            req   = vecs[i].req;
            rdy   = vecs[i].rdy;
            lst   = vecs[i].lst;
            tick();
            exp_oh = vecs[i].exp_vld ? (16'h0001 << vecs[i].exp_bin) : 16'h0000;
            check("vld", i, 32'(vld), 32'(vecs[i].exp_vld));
            if (vecs[i].chk_bin) check("bin", i, 32'(bin), 32'(vecs[i].exp_bin));
            check("oh", i, 32'(oh), 32'(exp_oh));
        end

        // WIDTH=10 wrap-around: 0, 9, 0, 9, ...
        req   = '0;
        rdy   = 1'b0;
        rst_n = 1'b0;
        tick();
        check("w10_reset_vld", 0, 32'(vld10), 32'd0);
        check("w10_reset_oh", 0, 32'(oh10), 32'd0);
        rst_n = 1'b1;
        req10 = 10'h201;
        rdy10 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            exp10    = (i % 2 == 1) ? 4'd9 : 4'd0;
            exp_oh10 = 10'h001 << exp10;
            check("w10_vld", i, 32'(vld10), 32'd1);
            check("w10_bin", i, 32'(bin10), 32'(exp10));
            check("w10_oh", i, 32'(oh10), 32'(exp_oh10));
        end
        req10 = '0;
        tick();
        check("w10_idle_vld", 0, 32'(vld10), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
